// File: rtl/adder4bit_sched.sv
// adder4bit_sched: round-robin scheduler that shares one 4-bit adder between two
// requesters and runs each wide addition through it one nibble per cycle.

module adder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module adder4bit_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req1_cin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout,
  output logic                 res_id,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_next;

  logic [W-1:0]  a_reg, b_reg, acc, acc_next;
  logic [W-1:0]  a_sh, b_sh, nib_mask, nib_val;
  logic [KW-1:0] k;
  logic [KW+1:0] shamt;
  logic [3:0]    nib_sum;
  logic          nib_cout, carry, last_id, grant, accept;

  // The current nibble is brought down to bit 0 for the adder and its result
  // is shifted back up to be merged into the accumulator.
  assign shamt    = {k, 2'b00};
  assign a_sh     = a_reg >> shamt;
  assign b_sh     = b_reg >> shamt;
  assign nib_mask = W'(4'hF) << shamt;
  assign nib_val  = W'(nib_sum) << shamt;
  assign acc_next = (acc & ~nib_mask) | nib_val;

  adder4bit u_adder (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // On a tie the requester that did not win last time gets the grant.
  assign grant  = (req0_valid && req1_valid) ? ~last_id : req1_valid;
  assign accept = req0_ready || req1_ready;

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = !rst && req0_valid && !grant;
        req1_ready = !rst && req1_valid && grant;
        if (req0_ready || req1_ready) state_next = ADD;
      end
      ADD:     if (k == KLAST) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // res_sum/res_cout only change when an operation completes, so they hold
  // steady through DONE and between results while acc is being built.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      k        <= '0;
      carry    <= 1'b0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_id   <= 1'b0;
      last_id  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg   <= grant ? req1_a : req0_a;
            b_reg   <= grant ? req1_b : req0_b;
            carry   <= grant ? req1_cin : req0_cin;
            acc     <= '0;
            k       <= '0;
            res_id  <= grant;
            last_id <= grant;
          end
        end
        ADD: begin
          acc   <= acc_next;
          carry <= nib_cout;
          if (k == KLAST) begin
            res_sum  <= acc_next;
            res_cout <= nib_cout;
            k        <= '0;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder4bit_sched.sv
// tb_adder4bit_sched: scoreboard-checked bench for the nibble-serial adder scheduler,
// plus a second NIBBLES=1 instance for the single-cycle ADD variant.

module tb_adder4bit_sched;
  localparam int N = 4;
  localparam int W = 16;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] sum;
    logic        cout;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, res_sum;
  logic         res_valid, res_ready, res_cout, res_id, busy;

  logic         n1_req0_valid, n1_req0_ready, n1_req0_cin;
  logic         n1_req1_valid, n1_req1_ready, n1_req1_cin;
  logic [3:0]   n1_req0_a, n1_req0_b, n1_req1_a, n1_req1_b, n1_res_sum;
  logic         n1_res_valid, n1_res_ready, n1_res_cout, n1_res_id, n1_busy;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  adder4bit_sched #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_id(res_id), .busy(busy)
  );

  adder4bit_sched #(.NIBBLES(1)) dut_n1 (
    .clk(clk), .rst(rst),
    .req0_valid(n1_req0_valid), .req0_ready(n1_req0_ready), .req0_a(n1_req0_a), .req0_b(n1_req0_b),
    .req0_cin(n1_req0_cin),
    .req1_valid(n1_req1_valid), .req1_ready(n1_req1_ready), .req1_a(n1_req1_a), .req1_b(n1_req1_b),
    .req1_cin(n1_req1_cin),
    .res_valid(n1_res_valid), .res_ready(n1_res_ready), .res_sum(n1_res_sum), .res_cout(n1_res_cout),
    .res_id(n1_res_id), .busy(n1_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request, push its expected result at the grant, then scramble operands.
  task automatic applyStimulus(input vec_t v);
    int cyc;
    bit seen;
    if (v.id == 1'b0) begin
      req0_a = v.a; req0_b = v.b; req0_cin = v.cin; req0_valid = 1'b1;
    end else begin
      req1_a = v.a; req1_b = v.b; req1_cin = v.cin; req1_valid = 1'b1;
    end
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if ((v.id == 1'b0 && req0_ready) || (v.id == 1'b1 && req1_ready)) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no ready for id=%0d, expected a grant", v.id);
    end else begin
      sbq.push_back('{id: v.id, sum: v.sum, cout: v.cout});
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
    req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
    checkOutput("ready_drop", 32'({req0_ready, req1_ready}), 32'd0);
  endtask

  task automatic waitDrain(input string name);
    int cyc = 0;
    while (sbq.size() != 0 && cyc < 60) begin
      @(posedge clk);
      cyc++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: %0d results outstanding, expected 0", name, sbq.size());
      sbq.delete();
    end
    #1;
  endtask

  // Scoreboard consumer: every result handshake is matched against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got id=%0d sum=0x%0h, expected none", res_id, res_sum);
      end else begin
        e = sbq.pop_front();
        checkOutput("res_sum", 32'(res_sum), 32'(e.sum));
        checkOutput("res_cout", 32'(res_cout), 32'(e.cout));
        checkOutput("res_id", 32'(res_id), 32'(e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    int   cyc, lat, g;
    bit   seen;

    tbl[0] = '{id: 1'b0, a: 16'h1234, b: 16'h0FCD, cin: 1'b0, sum: 16'h2201, cout: 1'b0};
    tbl[1] = '{id: 1'b1, a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
    tbl[2] = '{id: 1'b1, a: 16'h7FFF, b: 16'h0000, cin: 1'b1, sum: 16'h8000, cout: 1'b0};
    tbl[3] = '{id: 1'b0, a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1};
    tbl[4] = '{id: 1'b0, a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
    tbl[5] = '{id: 1'b1, a: 16'hABCD, b: 16'h1111, cin: 1'b0, sum: 16'hBCDE, cout: 1'b0};
    tbl[6] = '{id: 1'b0, a: 16'h0F0F, b: 16'h00F1, cin: 1'b0, sum: 16'h1000, cout: 1'b0};
    tbl[7] = '{id: 1'b1, a: 16'h00FF, b: 16'h0001, cin: 1'b0, sum: 16'h0100, cout: 1'b0};

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    res_ready = 1'b1;
    n1_req0_valid = 1'b0; n1_req0_a = '0; n1_req0_b = '0; n1_req0_cin = 1'b0;
    n1_req1_valid = 1'b0; n1_req1_a = '0; n1_req1_b = '0; n1_req1_cin = 1'b0;
    n1_res_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_res_sum", 32'(res_sum), 32'd0);
    checkOutput("rst_res_cout_id", 32'({res_cout, res_id}), 32'd0);
    checkOutput("rst_readys", 32'({req0_ready, req1_ready}), 32'd0);
    checkOutput("rst_n1_valid_busy", 32'({n1_res_valid, n1_busy}), 32'd0);
    rst = 1'b0;

    $display("[TB] arbitration under continuous dual load");
    req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 16'h0010; req1_b = 16'h0010; req1_cin = 1'b0; req1_valid = 1'b1;
    g = 0;
    cyc = 0;
    while (g < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (req0_ready || req1_ready) begin
        checkOutput("arb_one_hot", 32'(req0_ready & req1_ready), 32'd0);
        checkOutput("arb_grant", 32'(req1_ready), 32'(g % 2));
        if (req1_ready) sbq.push_back('{id: 1'b1, sum: 16'h0020, cout: 1'b0});
        else            sbq.push_back('{id: 1'b0, sum: 16'h0002, cout: 1'b0});
        g++;
      end
    end
    if (g < 4) begin
      total++;
      bad++;
      $display("[TB] FAIL arb_timeout: got %0d grants, expected 4", g);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitDrain("arb_drain");

    $display("[TB] table-driven vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i]);
      if (i == 0) begin
        lat = 0;
        while (!res_valid && lat < 20) begin
          @(posedge clk);
          #1;
          lat++;
        end
        checkOutput("latency", 32'(lat), 32'(N));
      end
      waitDrain("table_drain");
    end

    $display("[TB] back-pressure in DONE");
    res_ready = 1'b0;
    v = '{id: 1'b0, a: 16'h1111, b: 16'h2222, cin: 1'b0, sum: 16'h3333, cout: 1'b0};
    applyStimulus(v);
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("bp_reach_done", 32'(res_valid), 32'd1);
    req1_a = 16'h0005; req1_b = 16'h0003; req1_cin = 1'b0; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(res_valid), 32'd1);
      checkOutput("bp_sum", 32'(res_sum), 32'h3333);
      checkOutput("bp_id_busy", 32'({res_id, busy}), 32'b01);
      checkOutput("bp_req1_ready", 32'(req1_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_no_bypass", 32'(req1_ready), 32'd0);
    @(negedge clk);
    checkOutput("bp_grant_req1", 32'(req1_ready), 32'd1);
    if (req1_ready) sbq.push_back('{id: 1'b1, sum: 16'h0008, cout: 1'b0});
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    waitDrain("bp_drain");

    $display("[TB] reset during ADD");
    req0_a = 16'h4444; req0_b = 16'h1111; req0_cin = 1'b0; req0_valid = 1'b1;
    cyc = 0;
    while (!req0_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("rst_accept", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_res_sum", 32'(res_sum), 32'd0);
    checkOutput("midrst_cout_id", 32'({res_cout, res_id}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    checkOutput("midrst_no_result", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    v = '{id: 1'b0, a: 16'h00FF, b: 16'h0001, cin: 1'b0, sum: 16'h0100, cout: 1'b0};
    applyStimulus(v);
    waitDrain("midrst_drain");

    $display("[TB] NIBBLES=1 variant");
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        n1_req0_a = 4'hF; n1_req0_b = 4'h1; n1_req0_cin = 1'b1; n1_req0_valid = 1'b1;
      end else begin
        n1_req1_a = 4'h7; n1_req1_b = 4'h8; n1_req1_cin = 1'b0; n1_req1_valid = 1'b1;
      end
      @(negedge clk);
      checkOutput("n1_ready", 32'({n1_req1_ready, n1_req0_ready}), (i == 0) ? 32'b01 : 32'b10);
      @(posedge clk);
      #1;
      n1_req0_valid = 1'b0;
      n1_req1_valid = 1'b0;
      checkOutput("n1_add_no_valid", 32'(n1_res_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("n1_res_valid", 32'(n1_res_valid), 32'd1);
      checkOutput("n1_res_sum", 32'(n1_res_sum), (i == 0) ? 32'h1 : 32'hF);
      checkOutput("n1_cout_id", 32'({n1_res_cout, n1_res_id}), (i == 0) ? 32'b10 : 32'b01);
      @(posedge clk);
      #1;
    end

    checkOutput("sb_empty_end", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder4bit_sched.md
# adder4bit_sched

Time-multiplexed scheduler that shares a single `adder4bit` instance between two requesters and sequences wide additions through it one nibble per cycle. Each requester submits a pair of operands of width `4*NIBBLES` plus a carry-in over a valid/ready handshake. The block arbitrates round-robin, chains the carry through a register across nibble cycles, and returns the sum, carry-out and requester ID on a valid/ready result port. It sits between the arithmetic clients and the 4-bit adder datapath, so a single narrow adder serves wide, shared traffic.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices per operand; operand width `W = 4*NIBBLES`; legal range 1..16.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: requester 0's operation is accepted this cycle.
- `req0_a`, `req0_b` in W: requester 0 operands.
- `req0_cin` in 1: requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as requester 0, for requester 1.
- `res_valid` out 1: result is available.
- `res_ready` in 1: consumer accepts the result.
- `res_sum` out W: `a + b + cin`, modulo 2^W.
- `res_cout` out 1: carry out of the top nibble.
- `res_id` out 1: index of the requester that owns the result.
- `busy` out 1: high in every state except IDLE.

## Operation
- Exactly one `adder4bit` instance.
  - Inputs: nibble `k` of the captured A and B, and the carry register.
  - Outputs: its sum is written into nibble `k` of the sum register; its carryout is loaded into the carry register.
- The FSM has three states: IDLE, ADD, DONE.
- **IDLE**
  - Grant logic:
    - If only one `reqN_valid` is high, grant that requester.
    - If both are high, grant the one that is not `last_id`.
  - `reqN_ready = (state==IDLE) && grant==N`. This is combinational and may depend on `valid`.
  - On `valid && ready`:
    - capture `a`, `b` and `cin` (the carry register takes `cin`);
    - set `k=0` and `res_id=N`, and load `last_id=N`;
    - go to ADD.
  - If no request is valid, stay in IDLE; neither ready is asserted.
- **ADD**
  - Each cycle, the adder result for nibble `k` is registered and the carry register is updated.
  - If `k==NIBBLES-1`, go to DONE with `res_cout` equal to the final carry. Otherwise `k` increments.
  - Both `reqN_ready` outputs are low.
- **DONE**
  - `res_valid=1`; `res_sum`, `res_cout` and `res_id` are held stable.
  - On `res_ready`, go to IDLE. A new grant is possible only in the following cycle: there is no bypass from DONE.
  - While `res_ready` is low, stay in DONE indefinitely. Pending requests wait and keep their `ready` low.
- Operands are sampled only at acceptance. Changes to `reqN_a/b/cin` after acceptance have no effect.
- `res_sum` and `res_cout` are meaningful only while `res_valid` is high. Between results they hold the last value.

## Timing
- Reset values:
  - `state=IDLE`, `k=0`, carry register 0;
  - `res_valid=0`, `res_sum=0`, `res_cout=0`, `res_id=0`;
  - `busy=0`, both readys 0;
  - `last_id=1`, so requester 0 wins the first tie.
- Latency:
  - Acceptance happens at edge T.
  - ADD occupies the cycles after edges T .. T+NIBBLES-1.
  - `res_valid` rises after edge T+NIBBLES.
- Peak throughput is one operation per `NIBBLES+2` cycles: IDLE, NIBBLES × ADD, DONE with `res_ready=1`.
- Boundary conditions:
  - Simultaneous valids alternate grants. Under continuous dual load the grant sequence is 0,1,0,1,...
  - `NIBBLES=1` makes ADD a single cycle.
  - Full-scale wrap: `res_sum` wraps modulo 2^W and the overflow appears only on `res_cout`.
  - `rst` asserted in any state (mid-ADD or DONE) immediately returns all state and outputs to reset values. The in-flight operation is dropped with no result and no ready.
  - `res_ready` high outside DONE is ignored.

## Test plan
- **Single add, NIBBLES=4.** req0 with a=0x1234, b=0x0FCD, cin=0 → `req0_ready` for 1 cycle; 4 cycles later `res_valid` with sum=0x2201, cout=0, id=0.
- **Carry chain through all nibbles.** req1 with a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, id=1. Then a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0.
- **Arbitration.**
  - Both valid continuously. req0: a=0x0001, b=0x0001. req1: a=0x0010, b=0x0010.
  - Required: results alternate id 0,1,0,1 with sums 0x0002 and 0x0020.
  - Each requester's ready pulses exactly once per grant.
- **Back-pressure.** Hold `res_ready=0` for 10 cycles in DONE → `res_valid`, sum and id stay stable, `busy=1`, no ready to a pending req1. Release → IDLE, then grant req1 the next cycle.
- **Reset mid-operation.** Assert `rst` during the second ADD cycle → all outputs 0 immediately, no `res_valid`. After release, a fresh req0 of 0x00FF+0x0001 yields 0x0100.
- **Parameter variant.** NIBBLES=1: a=0xF, b=0x1, cin=1 → sum=0x1, cout=1, and `res_valid` 1 cycle after acceptance.
